// File: rtl/pix_buff_pkg.sv
// Shared definitions for the pixel buffer write path: state encoding,
// default bus widths and the pixel used to pad odd-length lines.
package pix_buff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_e;

    localparam int PIX_WIDTH_DEF  = 16;
    localparam int WORD_WIDTH_DEF = 32;
    localparam int LINE_CNT_WIDTH = 11;

    localparam logic [15:0] PAD_PIX = 16'h0000;

endpackage

// File: rtl/pix_buff_packer_if.sv
// Camera pixel stream in, FIFO write port out, plus frame/line status.
// The packer takes the slave view; the camera/FIFO side takes the master view.
interface pix_buff_packer_if
    import pix_buff_pkg::*;
#(
    parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
);
    logic                      frame_start;
    logic                      pix_vld;
    logic [PIX_WIDTH-1:0]      pix_data;
    logic                      pix_last;
    logic [WORD_WIDTH-1:0]     fifo_wr_data;
    logic                      fifo_wr_en;
    logic                      fifo_full;
    logic                      overflow;
    logic [CNT_WIDTH-1:0]      drop_cnt;
    logic [LINE_CNT_WIDTH-1:0] line_cnt;
    logic                      frame_done;

    modport master (
        output frame_start, pix_vld, pix_data, pix_last, fifo_full,
        input  fifo_wr_data, fifo_wr_en, overflow, drop_cnt, line_cnt, frame_done
    );

    modport slave (
        input  frame_start, pix_vld, pix_data, pix_last, fifo_full,
        output fifo_wr_data, fifo_wr_en, overflow, drop_cnt, line_cnt, frame_done
    );
endinterface

// File: rtl/pix_buff_packer.sv
// Packs pairs of camera pixels into FIFO words {odd, even}, pads odd-length
// lines, and on FIFO overflow discards the rest of the frame while counting.
module pix_buff_packer
    import pix_buff_pkg::*;
#(
    parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int V_ACTIVE   = 480,
    parameter int CNT_WIDTH  = 16
) (
    input logic              wr_clk,
    input logic              wr_rst,
    pix_buff_packer_if.slave bus
);

    if (WORD_WIDTH != 2 * PIX_WIDTH) begin : g_width_check
        $error("pix_buff_packer: WORD_WIDTH must be 2*PIX_WIDTH");
    end

    state_e                    state_q, eff_state, state_nxt;
    logic [PIX_WIDTH-1:0]      low_half_q;
    logic                      phase_q, eff_phase, phase_nxt;
    logic                      pend_q, pad_q;
    logic [WORD_WIDTH-1:0]     word_q, word_nxt;
    logic [LINE_CNT_WIDTH-1:0] line_q, eff_line, line_nxt;
    logic [CNT_WIDTH-1:0]      drop_q, eff_drop, drop_nxt;
    logic                      overflow_q, frame_done_q;
    logic                      ovf, take, dropped, queue, eof;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // frame_start and overflow are resolved first; the current pixel then
    // sees the resulting state, so a pixel beside frame_start opens the frame.
    always_comb begin
        ovf       = pend_q & bus.fifo_full;
        eff_state = state_q;
        eff_line  = line_q;
        eff_phase = phase_q;
        eff_drop  = drop_q;
        if (bus.frame_start) begin
            eff_state = ACTIVE;
            eff_line  = '0;
            eff_phase = 1'b0;
            eff_drop  = '0;
        end else if (ovf) begin
            eff_state = DROP;
            eff_drop  = sat_add(drop_q, pad_q ? 2'd1 : 2'd2);
        end

        take     = bus.pix_vld & (eff_state == ACTIVE);
        dropped  = bus.pix_vld & (eff_state == DROP);
        line_nxt = eff_line + LINE_CNT_WIDTH'(bus.pix_vld & bus.pix_last
                                              & (eff_state != IDLE));
        eof      = take & bus.pix_last & (line_nxt == LINE_CNT_WIDTH'(V_ACTIVE));
        queue    = take & (eff_phase | bus.pix_last);
        word_nxt = eff_phase ? {bus.pix_data, low_half_q}
                             : {PIX_WIDTH'(PAD_PIX), bus.pix_data};
        drop_nxt  = sat_add(eff_drop, {1'b0, dropped});
        phase_nxt = take ? (~eff_phase & ~bus.pix_last) : eff_phase;
        state_nxt = eof ? IDLE : eff_state;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q      <= IDLE;
            low_half_q   <= '0;
            phase_q      <= 1'b0;
            pend_q       <= 1'b0;
            pad_q        <= 1'b0;
            word_q       <= '0;
            line_q       <= '0;
            drop_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            phase_q      <= phase_nxt;
            pend_q       <= queue;
            pad_q        <= queue & ~eff_phase;
            line_q       <= line_nxt;
            drop_q       <= drop_nxt;
            overflow_q   <= ~bus.frame_start & (overflow_q | ovf);
            frame_done_q <= eof;
            if (take & ~eff_phase) low_half_q <= bus.pix_data;
            if (queue)             word_q     <= word_nxt;
        end
    end

    // The write enable alone looks at fifo_full combinationally, so a full
    // FIFO suppresses the write in the very cycle it is seen.
    assign bus.fifo_wr_en   = pend_q & ~bus.fifo_full;
    assign bus.fifo_wr_data = word_q;
    assign bus.overflow     = overflow_q;
    assign bus.drop_cnt     = drop_q;
    assign bus.line_cnt     = line_q;
    assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_pix_buff_packer.sv
// Bench for pix_buff_packer: directed scenarios plus randomized traffic,
// each cycle compared against a pixel-queue reference model.
module tb_pix_buff_packer;

    localparam int VA   = 2;
    localparam int DMAX = 65535;

    logic wr_clk = 1'b0;
    logic wr_rst;
    always #5 wr_clk = ~wr_clk;

    pix_buff_packer_if #(.PIX_WIDTH(16), .WORD_WIDTH(32), .CNT_WIDTH(16)) bus ();

    pix_buff_packer #(
        .PIX_WIDTH(16), .WORD_WIDTH(32), .V_ACTIVE(VA), .CNT_WIDTH(16)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rst(wr_rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // reference model: mode 0 idle, 1 active, 2 drop
    int          m_mode = 0;
    logic [15:0] m_hold[$];
    bit          m_pend = 0, m_pad = 0, m_done = 0, m_ovf = 0, m_known = 0;
    logic [31:0] m_word = '0;
    int          m_lines = 0, m_drops = 0;

    int          n_wr = 0, n_done = 0;
    logic [31:0] wr_log[$];

    function automatic int sat(input int x);
        return (x > DMAX) ? DMAX : x;
    endfunction

    task automatic model_step(input bit rst, input bit fs, input bit vld,
                              input logic [15:0] d, input bit last, input bit full);
        bit          ovf, np, npad;
        logic [31:0] nw;
        if (rst) begin
            m_mode = 0; m_hold.delete(); m_pend = 0; m_pad = 0; m_done = 0;
            m_ovf = 0; m_word = '0; m_lines = 0; m_drops = 0; m_known = 1;
            return;
        end
        ovf = m_pend && full;
        np = 0; npad = 0; nw = m_word; m_done = 0;
        if (fs) begin
            m_mode = 1; m_lines = 0; m_drops = 0; m_ovf = 0; m_hold.delete();
        end else if (ovf) begin
            m_ovf = 1; m_drops = sat(m_drops + (m_pad ? 1 : 2)); m_mode = 2;
        end
        if (vld && m_mode == 1) begin
            m_hold.push_back(d);
            if (m_hold.size() == 2) begin
                nw = {m_hold[1], m_hold[0]}; np = 1;
            end else if (last) begin
                nw = {16'h0000, m_hold[0]}; np = 1; npad = 1;
            end
            if (m_hold.size() == 2 || last) m_hold.delete();
            if (last) begin
                m_lines++;
                if (m_lines == VA) begin
                    m_done = 1; m_mode = 0;
                end
            end
        end else if (vld && m_mode == 2) begin
            m_drops = sat(m_drops + 1);
            if (last) m_lines++;
        end
        m_pend = np; m_pad = npad; m_word = nw;
    endtask

    task automatic cycle(input bit rst, input bit fs, input bit vld,
                         input logic [15:0] d, input bit last, input bit full);
        @(negedge wr_clk);
        wr_rst = rst; bus.frame_start = fs; bus.pix_vld = vld;
        bus.pix_data = d; bus.pix_last = last; bus.fifo_full = full;
        #1;
        if (m_known) begin
            total++;
            if (bus.fifo_wr_en !== (m_pend & ~full)) begin
                bad++;
                $display("FAIL wr_en got=%b exp=%b full=%b t=%0t",
                         bus.fifo_wr_en, m_pend & ~full, full, $time);
            end
            if (m_pend && !full) begin
                total++;
                if (bus.fifo_wr_data !== m_word) begin
                    bad++;
                    $display("FAIL wr_data got=%h exp=%h t=%0t", bus.fifo_wr_data, m_word, $time);
                end
            end
            total++;
            if (bus.frame_done !== m_done) begin
                bad++;
                $display("FAIL frame_done got=%b exp=%b t=%0t", bus.frame_done, m_done, $time);
            end
            total++;
            if (bus.overflow !== m_ovf) begin
                bad++;
                $display("FAIL overflow got=%b exp=%b t=%0t", bus.overflow, m_ovf, $time);
            end
            total++;
            if (bus.drop_cnt !== 16'(m_drops)) begin
                bad++;
                $display("FAIL drop_cnt got=%0d exp=%0d t=%0t", bus.drop_cnt, m_drops, $time);
            end
            total++;
            if (bus.line_cnt !== 11'(m_lines)) begin
                bad++;
                $display("FAIL line_cnt got=%0d exp=%0d t=%0t", bus.line_cnt, m_lines, $time);
            end
        end
        if (bus.fifo_wr_en === 1'b1) begin
            n_wr++;
            wr_log.push_back(bus.fifo_wr_data);
        end
        if (bus.frame_done === 1'b1) n_done++;
        model_step(rst, fs, vld, d, last, full);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0, 0, 0);
    endtask

    task automatic pix(input logic [15:0] d, input bit last, input bit full);
        cycle(0, 0, 1, d, last, full);
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (bus.fifo_wr_data !== 32'h0 || bus.fifo_wr_en !== 1'b0 || bus.overflow !== 1'b0 ||
            bus.drop_cnt !== 16'h0 || bus.line_cnt !== 11'h0 || bus.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL %s outputs got data=%h en=%b ovf=%b drop=%0d line=%0d done=%b exp all 0",
                     name, bus.fifo_wr_data, bus.fifo_wr_en, bus.overflow, bus.drop_cnt,
                     bus.line_cnt, bus.frame_done);
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 16'h0, 0, 0);
        cycle(1, 0, 0, 16'h0, 0, 0);
        check_all_zero("reset");
        idle(2);
    endtask

    task automatic test_pair();
        cycle(0, 1, 0, 16'h0, 0, 0);
        pix(16'h1111, 0, 0);
        pix(16'h2222, 0, 0);
        idle(1);
        total++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 32'h2222_1111) begin
            bad++;
            $display("FAIL pair got en=%b data=%h exp en=1 data=22221111",
                     bus.fifo_wr_en, bus.fifo_wr_data);
        end
        idle(1);
    endtask

    task automatic test_odd_line();
        cycle(0, 1, 0, 16'h0, 0, 0);
        wr_log.delete();
        pix(16'hAAAA, 0, 0);
        pix(16'hBBBB, 0, 0);
        pix(16'hCCCC, 1, 0);
        idle(2);
        total++;
        if (wr_log.size() != 2) begin
            bad++;
            $display("FAIL odd_line writes got=%0d exp=2", wr_log.size());
        end else if (wr_log[0] !== 32'hBBBB_AAAA || wr_log[1] !== 32'h0000_CCCC) begin
            bad++;
            $display("FAIL odd_line words got=%h,%h exp=bbbbaaaa,0000cccc", wr_log[0], wr_log[1]);
        end
        total++;
        if (bus.line_cnt !== 11'd1) begin
            bad++;
            $display("FAIL odd_line line_cnt got=%0d exp=1", bus.line_cnt);
        end
    endtask

    task automatic test_frame();
        int wr0, dn0;
        cycle(0, 1, 0, 16'h0, 0, 0);
        wr0 = n_wr; dn0 = n_done;
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < 4; p++) pix(16'($urandom), p == 3, 0);
        idle(2);
        total++;
        if (n_wr - wr0 != 4 || n_done - dn0 != 1) begin
            bad++;
            $display("FAIL frame got writes=%0d done=%0d exp writes=4 done=1",
                     n_wr - wr0, n_done - dn0);
        end
        wr0 = n_wr;
        for (int p = 0; p < 6; p++) pix(16'($urandom), p == 5, 0);
        idle(1);
        total++;
        if (n_wr != wr0) begin
            bad++;
            $display("FAIL idle_after_frame got writes=%0d exp=0", n_wr - wr0);
        end
    endtask

    task automatic test_overflow();
        int dn0;
        cycle(0, 1, 0, 16'h0, 0, 0);
        dn0 = n_done;
        for (int p = 0; p < 8; p++) pix(16'($urandom), p == 7, p >= 4);
        cycle(0, 0, 0, 16'h0, 0, 1);
        cycle(0, 0, 0, 16'h0, 0, 1);
        total++;
        if (bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd6 || n_done != dn0) begin
            bad++;
            $display("FAIL overflow got ovf=%b drop=%0d done=%0d exp ovf=1 drop=6 done=0",
                     bus.overflow, bus.drop_cnt, n_done - dn0);
        end
        idle(2);
    endtask

    task automatic test_abort();
        cycle(0, 1, 0, 16'h0, 0, 0);
        pix(16'h1234, 0, 0);
        cycle(0, 1, 0, 16'h0, 0, 0);
        wr_log.delete();
        pix(16'h5555, 0, 0);
        pix(16'h6666, 0, 0);
        idle(1);
        total++;
        if (wr_log.size() != 1 || bus.fifo_wr_data !== 32'h6666_5555 ||
            bus.drop_cnt !== 16'd0 || bus.line_cnt !== 11'd0 || bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL abort got writes=%0d data=%h drop=%0d line=%0d ovf=%b exp 1 66665555 0 0 0",
                     wr_log.size(), bus.fifo_wr_data, bus.drop_cnt, bus.line_cnt, bus.overflow);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        int wr0;
        cycle(0, 1, 0, 16'h0, 0, 0);
        pix(16'h0A0A, 0, 0);
        pix(16'h0B0B, 0, 0);
        cycle(1, 0, 1, 16'h0C0C, 0, 0);
        pix(16'h0D0D, 0, 0);
        check_all_zero("reset_mid");
        wr0 = n_wr;
        for (int p = 0; p < 5; p++) pix(16'($urandom), p == 4, 0);
        idle(1);
        total++;
        if (n_wr != wr0) begin
            bad++;
            $display("FAIL reset_mid_ignore got writes=%0d exp=0", n_wr - wr0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cycle(0, $urandom_range(63) == 0, $urandom_range(3) != 0, 16'($urandom),
                  $urandom_range(5) == 0, $urandom_range(7) == 0);
        end
        idle(3);
    endtask

    initial begin
        wr_rst = 1'b1;
        bus.frame_start = 1'b0; bus.pix_vld = 1'b0; bus.pix_data = '0;
        bus.pix_last = 1'b0; bus.fifo_full = 1'b0;
        test_reset();
        test_pair();
        test_odd_line();
        test_frame();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
